compare_sequencer: RTL
======================

# compare_sequencer

Multi-cycle magnitude comparator controller. It compares two WIDTH-bit unsigned operands by running a shared 2-bit greater-than slice over them, MSB pair first, one bit-pair per clock. It sits between a requester using a start/done handshake and the 2-bit comparator datapath, so wide compares need no wide combinational logic.

## Interface
- WIDTH, 8: operand width in bits. Must be even and ≥ 2. N = WIDTH/2 slices.
- clk  input  1  clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse. Sampled only when the state is IDLE or DONE.
- a  input  WIDTH  operand A. Captured on the accepting edge.
- b  input  WIDTH  operand B. Captured on the accepting edge.
- busy  output  1  high while a comparison is in progress (state RUN).
- done  output  1  one-cycle pulse when the result is valid.
- gt  output  1  A > B. Valid from done; held until the next accepted start.
- eq  output  1  A == B. Same validity as gt.
- lt  output  1  A < B. Same validity as gt.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - With start=1: capture a and b into a_s and b_s, set idx = N-1, clear the decided flag, clear gt/eq/lt, go to RUN.
  - With start=0: stay in IDLE.
- **RUN**, each cycle:
  - Present slice a_s[2·idx+1:2·idx] and b_s[2·idx+1:2·idx] to two slice instances: g_ab = A>B and g_ba = B>A.
  - If the decided flag is clear and g_ab=1: record gt and set decided.
  - If the decided flag is clear and g_ba=1: record lt and set decided.
  - If idx == 0: go to DONE. If no slice ever differed, eq=1.
  - Otherwise: idx decrements.
- **DONE**: done=1 for exactly one cycle.
  - With start=1: accept new operands exactly as in IDLE (back-to-back operation).
  - With start=0: go to IDLE.
- start while in RUN is ignored. No queuing.
- Exactly one of gt/eq/lt is 1 after any done. All three are 0 between an accepted start and its done.
- a and b may change freely after the accepting edge.
- Reset mid-operation aborts immediately to IDLE. No done is produced for the aborted request.

## Timing
- Reset values: busy=0, done=0, gt=0, eq=0, lt=0, state IDLE, idx=0.
- start accepted at edge 0. busy=1 from edge 0. Slices are evaluated on edges 1..N.
  - Full-length compare: the state enters DONE at edge N, done=1 and busy=0 during the cycle after edge N, and done drops at edge N+1.
  - Latency from the start edge to the done pulse is N cycles. The done cycle doubles as the next accept window.
- Early exit (with the macro): when the first differing slice is the k-th from the MSB (k=1..N), DONE is entered at edge k, giving latency k. Equal operands always take N.
- Result outputs are registered. They change only on the edge entering DONE, or on clearing at an accepted start.

## Configuration
- CMP_SEQ_EARLY_EXIT_EN defined: RUN goes to DONE in the same cycle the decided flag is first set, skipping the remaining slices.
- CMP_SEQ_EARLY_EXIT_EN undefined: RUN always walks all N slices. Latency is fixed at N regardless of data, and the decided flag only masks later slices.

## Structure
- Package cmp_seq_pkg holds:
  - state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the slice width constant SLICE_W=2.
- Sub-module gt2_slice: a combinational 2-bit greater-than, out = x > y. It is instantiated twice, once with (A,B) and once with (B,A).
- The sequencer itself holds:
  - the operand registers;
  - the idx counter, width clog2(N), minimum 1;
  - the decided flag and the FSM.

## Test plan
All cases use WIDTH=8, N=4.
- a=8'hA5, b=8'hA5, start pulse: eq=1, gt=0, lt=0, done exactly 4 cycles after the accepting edge.
- a=8'h80, b=8'h7F: gt=1; done after 1 cycle with CMP_SEQ_EARLY_EXIT_EN, after 4 without.
- a=8'h12, b=8'h13: lt=1, decided in the last slice, done after 4 cycles in both builds.
- a=8'h40, b=8'h10, then a second start with a=8'h01, b=8'h02 held high during the done cycle: the first result is gt, the second is accepted without an IDLE cycle and gives lt.
- start pulsed with different operands while busy=1: ignored, and the original result is reported.
- rst_n driven low 2 cycles into a compare: all outputs go to 0 asynchronously, no done follows, and a new start after release completes normally.

Source files
------------

// File: rtl/cmp_seq_pkg.sv
// Shared types and constants for the multi-cycle magnitude comparator.
// Optional feature macro: CMP_SEQ_EARLY_EXIT_EN.
package cmp_seq_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gt2_slice.sv
// Combinational 2-bit unsigned greater-than slice.
// Used twice by the sequencer, once per operand order.
module gt2_slice
  import cmp_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  output logic               out
);

  assign out = (x > y);

endmodule

// File: rtl/compare_sequencer.sv
// Walks two operands MSB slice first through a shared 2-bit comparator.
// Macro CMP_SEQ_EARLY_EXIT_EN ends the walk at the first differing slice.
module compare_sequencer
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_s;
  logic [WIDTH-1:0]   b_s;
  logic [IDX_W-1:0]   idx;
  logic               decided;
  logic               dec_gt;

  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic               g_ab;
  logic               g_ba;
  logic               hit;
  logic               dec_n;
  logic               gt_n;
  logic               lt_n;
  logic               last;
  logic               go_done;
  logic               accept;

  gt2_slice u_gt_ab (
    .x   (sa),
    .y   (sb),
    .out (g_ab)
  );

  gt2_slice u_gt_ba (
    .x   (sb),
    .y   (sa),
    .out (g_ba)
  );

  // Select the current slice and fold it into the running decision.
  always_comb begin
    sa      = SLICE_W'(a_s >> {idx, 1'b0});
    sb      = SLICE_W'(b_s >> {idx, 1'b0});
    hit     = !decided && (g_ab || g_ba);
    dec_n   = decided || hit;
    gt_n    = decided ? dec_gt : g_ab;
    lt_n    = dec_n && !gt_n;
    last    = (idx == '0);
`ifdef CMP_SEQ_EARLY_EXIT_EN
    go_done = last || hit;
`else
    go_done = last;
`endif
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  // Sequencer FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_s     <= '0;
      b_s     <= '0;
      idx     <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state   <= RUN;
        a_s     <= a;
        b_s     <= b;
        idx     <= IDX_TOP;
        decided <= 1'b0;
        dec_gt  <= 1'b0;
        busy    <= 1'b1;
        gt      <= 1'b0;
        eq      <= 1'b0;
        lt      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          RUN: begin
            decided <= dec_n;
            dec_gt  <= gt_n;
            if (go_done) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              gt    <= gt_n;
              lt    <= lt_n;
              eq    <= !dec_n;
            end else begin
              idx <= idx - 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
